wakeup_array: RTL and testbench

- Wakeup end of the Dispatch↔Wakeup protocol. Receives dispatched instructions, each with per-source dependency vectors.
- Holds instructions in NUM_ENTRIES slots and clears dependency bits on producer wakeup broadcasts.
- Selects the oldest fully-ready entry each cycle and issues it to the FU select stage through a valid/ready handshake.
- Drives entry_free back to Dispatch.

---
 rtl/wakeup_array_pkg.sv | 15 +
 rtl/wakeup_array_if.sv | 32 +++
 rtl/wakeup_array_age_select.sv | 28 ++
 rtl/wakeup_array.sv | 164 ++++++++++++++++
 tb/tb_wakeup_array.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/wakeup_array_pkg.sv
// Shared core constants and the scheduler entry record used by the wakeup array.
package wakeup_array_pkg;

   localparam int NUM_FUS = 2;
   localparam int DEP_W   = 2 * NUM_FUS;
   localparam int TAG_W   = 6;

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic [DEP_W-1:0] dep1;
      logic [DEP_W-1:0] dep2;
   } wakeup_entry_t;

endpackage

// File: rtl/wakeup_array_if.sv
// Dispatch/wakeup/issue bundle between Dispatch, the producers and the wakeup array.
interface wakeup_array_if #(
   parameter int NUM_ENTRIES = 8,
   parameter int DEP_W       = wakeup_array_pkg::DEP_W,
   parameter int TAG_W       = wakeup_array_pkg::TAG_W
);
   logic                           entry_free;
   logic                           dispatch_valid;
   logic                           src1_dp_en;
   logic                           src2_dp_en;
   logic [DEP_W-1:0]               src1_dp_loc;
   logic [DEP_W-1:0]               src2_dp_loc;
   logic [TAG_W-1:0]               dispatch_tag;
   logic [DEP_W-1:0]               wakeup_vec;
   logic                           issue_valid;
   logic                           issue_ready;
   logic [TAG_W-1:0]               issue_tag;
   logic [$clog2(NUM_ENTRIES):0]   occupancy;
   logic                           flush;

   modport master (
      output dispatch_valid, src1_dp_en, src2_dp_en, src1_dp_loc, src2_dp_loc,
             dispatch_tag, wakeup_vec, issue_ready, flush,
      input  entry_free, issue_valid, issue_tag, occupancy
   );

   modport slave (
      input  dispatch_valid, src1_dp_en, src2_dp_en, src1_dp_loc, src2_dp_loc,
             dispatch_tag, wakeup_vec, issue_ready, flush,
      output entry_free, issue_valid, issue_tag, occupancy
   );
endinterface

// File: rtl/wakeup_array_age_select.sv
// Oldest-ready picker: grants the ready slot that no other ready slot is older than.
module wakeup_age_select #(
   parameter int NUM_ENTRIES = 8
) (
   input  logic [NUM_ENTRIES-1:0] age [NUM_ENTRIES],
   input  logic [NUM_ENTRIES-1:0] ready,
   output logic [NUM_ENTRIES-1:0] grant,
   output logic                   found
);

   logic [NUM_ENTRIES-1:0] blocked;

   // age[j][i] set means j is older than i, so any older ready j blocks i
   always_comb begin
      blocked = '0;
      grant   = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         for (int j = 0; j < NUM_ENTRIES; j++) begin
            if (ready[j] && age[j][i]) begin
               blocked[i] = 1'b1;
            end
         end
         grant[i] = ready[i] && !blocked[i];
      end
      found = |ready;
   end

endmodule

// File: rtl/wakeup_array.sv
// Wakeup/issue scheduler array. Define WAKEUP_PERF_CNT_EN to add stall/issue counters.
module wakeup_array
   import wakeup_array_pkg::*;
#(
   parameter int NUM_ENTRIES = 8,
   parameter int DEP_W       = wakeup_array_pkg::DEP_W,
   parameter int TAG_W       = wakeup_array_pkg::TAG_W
) (
   input  logic clk,
   input  logic rst,
   wakeup_array_if.slave bus
`ifdef WAKEUP_PERF_CNT_EN
   ,
   output logic [31:0] stall_cycles,
   output logic [31:0] issue_count
`endif
);

   localparam int IDX_W = $clog2(NUM_ENTRIES);
   localparam int OCC_W = $clog2(NUM_ENTRIES) + 1;

   wakeup_entry_t          entry_q [NUM_ENTRIES];
   wakeup_entry_t          entry_d [NUM_ENTRIES];
   logic [NUM_ENTRIES-1:0] age_q   [NUM_ENTRIES];
   logic [NUM_ENTRIES-1:0] age_d   [NUM_ENTRIES];
   logic [OCC_W-1:0]       occ_q, occ_d;
   logic [TAG_W-1:0]       last_tag_q, last_tag_d;

   logic [NUM_ENTRIES-1:0] valid_vec;
   logic [NUM_ENTRIES-1:0] ready;
   logic [NUM_ENTRIES-1:0] grant;
   logic                   found;
   logic [TAG_W-1:0]       sel_tag;
   logic [IDX_W-1:0]       free_idx;
   logic                   any_free;
   logic                   issue_fire;
   logic                   dispatch_acc;
   logic [DEP_W-1:0]       new_dep1;
   logic [DEP_W-1:0]       new_dep2;

   // Slot status, lowest free slot and the tag of the granted slot, all from registers
   always_comb begin
      free_idx = '0;
      sel_tag  = '0;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
         valid_vec[i] = entry_q[i].valid;
         ready[i]     = entry_q[i].valid && (entry_q[i].dep1 == '0) && (entry_q[i].dep2 == '0);
         if (!entry_q[i].valid) begin
            free_idx = IDX_W'(i);
         end
         if (grant[i]) begin
            sel_tag = sel_tag | entry_q[i].tag;
         end
      end
      any_free = ~&valid_vec;
   end

   wakeup_age_select #(.NUM_ENTRIES(NUM_ENTRIES)) u_age_select (
      .age   (age_q),
      .ready (ready),
      .grant (grant),
      .found (found)
   );

   always_comb begin
      bus.entry_free  = any_free;
      bus.issue_valid = found;
      bus.issue_tag   = found ? sel_tag : last_tag_q;
      bus.occupancy   = occ_q;
      issue_fire      = found && bus.issue_ready;
      dispatch_acc    = bus.dispatch_valid && any_free && !bus.flush;
      new_dep1        = (bus.src1_dp_en ? bus.src1_dp_loc : '0) & ~bus.wakeup_vec;
      new_dep2        = (bus.src2_dp_en ? bus.src2_dp_loc : '0) & ~bus.wakeup_vec;
      last_tag_d      = bus.issue_tag;
   end

   // Wakeup clears first, then issue frees its slot, dispatch fills a free one, flush wins
   always_comb begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         entry_d[i]      = entry_q[i];
         age_d[i]        = age_q[i];
         entry_d[i].dep1 = entry_q[i].dep1 & ~bus.wakeup_vec;
         entry_d[i].dep2 = entry_q[i].dep2 & ~bus.wakeup_vec;
         if (issue_fire && grant[i]) begin
            entry_d[i].valid = 1'b0;
         end
      end
      if (dispatch_acc) begin
         entry_d[free_idx].valid = 1'b1;
         entry_d[free_idx].tag   = bus.dispatch_tag;
         entry_d[free_idx].dep1  = new_dep1;
         entry_d[free_idx].dep2  = new_dep2;
         age_d[free_idx]         = '0;
         for (int j = 0; j < NUM_ENTRIES; j++) begin
            age_d[j][free_idx] = valid_vec[j];
         end
      end
      if (bus.flush) begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            entry_d[i].valid = 1'b0;
         end
      end
   end

   always_comb begin
      occ_d = occ_q;
      if (bus.flush) begin
         occ_d = '0;
      end else if (dispatch_acc && !issue_fire) begin
         occ_d = occ_q + OCC_W'(1);
      end else if (!dispatch_acc && issue_fire) begin
         occ_d = occ_q - OCC_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            entry_q[i] <= '0;
            age_q[i]   <= '0;
         end
         occ_q      <= '0;
         last_tag_q <= '0;
      end else begin
         for (int i = 0; i < NUM_ENTRIES; i++) begin
            entry_q[i] <= entry_d[i];
            age_q[i]   <= age_d[i];
         end
         occ_q      <= occ_d;
         last_tag_q <= last_tag_d;
      end
   end

`ifdef WAKEUP_PERF_CNT_EN
   logic [31:0] stall_cycles_q, stall_cycles_d;
   logic [31:0] issue_count_q, issue_count_d;

   // Saturating event counters
   always_comb begin
      stall_cycles_d = stall_cycles_q;
      issue_count_d  = issue_count_q;
      if (bus.dispatch_valid && !any_free && (stall_cycles_q != '1)) begin
         stall_cycles_d = stall_cycles_q + 32'd1;
      end
      if (issue_fire && (issue_count_q != '1)) begin
         issue_count_d = issue_count_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles_q <= '0;
         issue_count_q  <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
         issue_count_q  <= issue_count_d;
      end
   end

   assign stall_cycles = stall_cycles_q;
   assign issue_count  = issue_count_q;
`endif

endmodule

// File: tb/tb_wakeup_array.sv
// Directed self-checking bench for wakeup_array: latency, bypass, age order, full/flush/reset.
module tb_wakeup_array;

   logic clk;
   logic rst;
   int   test_count;
   int   fail_count;

   wakeup_array_if #(.NUM_ENTRIES(8), .DEP_W(4), .TAG_W(6)) bus_if ();

`ifdef WAKEUP_PERF_CNT_EN
   logic [31:0] stall_cycles;
   logic [31:0] issue_count;
`endif

   wakeup_array #(.NUM_ENTRIES(8), .DEP_W(4), .TAG_W(6)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
`ifdef WAKEUP_PERF_CNT_EN
      ,
      .stall_cycles (stall_cycles),
      .issue_count  (issue_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      bus_if.dispatch_valid = 1'b0;
      bus_if.src1_dp_en     = 1'b0;
      bus_if.src2_dp_en     = 1'b0;
      bus_if.src1_dp_loc    = '0;
      bus_if.src2_dp_loc    = '0;
      bus_if.dispatch_tag   = '0;
      bus_if.wakeup_vec     = '0;
      bus_if.flush          = 1'b0;
   endtask

   task automatic apply_dispatch(input logic [5:0] tag, input logic en1, input logic [3:0] loc1,
                                 input logic en2, input logic [3:0] loc2);
      bus_if.dispatch_valid = 1'b1;
      bus_if.dispatch_tag   = tag;
      bus_if.src1_dp_en     = en1;
      bus_if.src1_dp_loc    = loc1;
      bus_if.src2_dp_en     = en2;
      bus_if.src2_dp_loc    = loc2;
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      test_count++;
      assert (observed === expected) else begin
         fail_count++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   logic [5:0] order5 [8];

   initial begin
      test_count = 0;
      fail_count = 0;
      order5 = '{6'd10, 6'd11, 6'd12, 6'd14, 6'd15, 6'd16, 6'd17, 6'd20};
      set_idle();
      bus_if.issue_ready = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;

      check_output("rst_entry_free", 32'(bus_if.entry_free), 32'd1);
      check_output("rst_issue_valid", 32'(bus_if.issue_valid), 32'd0);
      check_output("rst_issue_tag", 32'(bus_if.issue_tag), 32'd0);
      check_output("rst_occupancy", 32'(bus_if.occupancy), 32'd0);

      // Dep-free dispatch issues the following cycle
      apply_dispatch(6'd5, 1'b0, 4'b0000, 1'b0, 4'b0000);
      tick();
      set_idle();
      check_output("t1_issue_valid", 32'(bus_if.issue_valid), 32'd1);
      check_output("t1_issue_tag", 32'(bus_if.issue_tag), 32'd5);
      check_output("t1_occupancy", 32'(bus_if.occupancy), 32'd1);
      tick();
      check_output("t1_hold_valid", 32'(bus_if.issue_valid), 32'd1);
      check_output("t1_hold_occ", 32'(bus_if.occupancy), 32'd1);
      bus_if.issue_ready = 1'b1;
      tick();
      bus_if.issue_ready = 1'b0;
      check_output("t1_drain_occ", 32'(bus_if.occupancy), 32'd0);
      check_output("t1_drain_valid", 32'(bus_if.issue_valid), 32'd0);
      check_output("t1_held_tag", 32'(bus_if.issue_tag), 32'd5);

      // Wakeup on an unrelated bit leaves the entry waiting; the right bit releases it
      apply_dispatch(6'd3, 1'b1, 4'b0010, 1'b0, 4'b0000);
      tick();
      set_idle();
      check_output("t2_wait_valid", 32'(bus_if.issue_valid), 32'd0);
      check_output("t2_occupancy", 32'(bus_if.occupancy), 32'd1);
      bus_if.wakeup_vec = 4'b0001;
      tick();
      bus_if.wakeup_vec = 4'b0000;
      check_output("t2_other_bit", 32'(bus_if.issue_valid), 32'd0);
      bus_if.wakeup_vec = 4'b0010;
      tick();
      bus_if.wakeup_vec = 4'b0000;
      check_output("t2_woken_valid", 32'(bus_if.issue_valid), 32'd1);
      check_output("t2_woken_tag", 32'(bus_if.issue_tag), 32'd3);
      bus_if.issue_ready = 1'b1;
      tick();
      bus_if.issue_ready = 1'b0;
      check_output("t2_drain_occ", 32'(bus_if.occupancy), 32'd0);

      // Same-cycle bypass; disabled src1 location must be ignored
      apply_dispatch(6'd9, 1'b0, 4'b1111, 1'b1, 4'b0001);
      bus_if.wakeup_vec = 4'b0001;
      tick();
      set_idle();
      check_output("t3_bypass_valid", 32'(bus_if.issue_valid), 32'd1);
      check_output("t3_bypass_tag", 32'(bus_if.issue_tag), 32'd9);
      bus_if.issue_ready = 1'b1;
      tick();
      bus_if.issue_ready = 1'b0;
      check_output("t3_drain_occ", 32'(bus_if.occupancy), 32'd0);

      // Fill, reject an extra dispatch, then drain in age order
      for (int t = 0; t < 8; t++) begin
         apply_dispatch(6'(t), 1'b1, 4'b1000, 1'b0, 4'b0000);
         tick();
      end
      set_idle();
      check_output("t4_full_free", 32'(bus_if.entry_free), 32'd0);
      check_output("t4_full_occ", 32'(bus_if.occupancy), 32'd8);
      apply_dispatch(6'd60, 1'b0, 4'b0000, 1'b0, 4'b0000);
      tick();
      set_idle();
      check_output("t4_reject_occ", 32'(bus_if.occupancy), 32'd8);
      check_output("t4_reject_valid", 32'(bus_if.issue_valid), 32'd0);
      bus_if.wakeup_vec = 4'b1000;
      tick();
      bus_if.wakeup_vec = 4'b0000;
      bus_if.issue_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check_output("t4_order_valid", 32'(bus_if.issue_valid), 32'd1);
         check_output("t4_order_tag", 32'(bus_if.issue_tag), 32'(i));
         tick();
      end
      bus_if.issue_ready = 1'b0;
      check_output("t4_empty_occ", 32'(bus_if.occupancy), 32'd0);
      check_output("t4_empty_valid", 32'(bus_if.issue_valid), 32'd0);
      check_output("t4_empty_free", 32'(bus_if.entry_free), 32'd1);

      // Full array: issue frees slot 3 but the concurrent dispatch is refused
      for (int t = 0; t < 8; t++) begin
         apply_dispatch(6'(10 + t), 1'b1, (t == 3) ? 4'b0100 : 4'b1000, 1'b0, 4'b0000);
         tick();
      end
      set_idle();
      check_output("t5_full_free", 32'(bus_if.entry_free), 32'd0);
      bus_if.wakeup_vec = 4'b0100;
      tick();
      bus_if.wakeup_vec = 4'b0000;
      check_output("t5_one_valid", 32'(bus_if.issue_valid), 32'd1);
      check_output("t5_one_tag", 32'(bus_if.issue_tag), 32'd13);
      bus_if.issue_ready = 1'b1;
      apply_dispatch(6'd20, 1'b0, 4'b0000, 1'b0, 4'b0000);
      tick();
      bus_if.issue_ready = 1'b0;
      set_idle();
      check_output("t5_refused_occ", 32'(bus_if.occupancy), 32'd7);
      check_output("t5_refused_free", 32'(bus_if.entry_free), 32'd1);
      check_output("t5_refused_valid", 32'(bus_if.issue_valid), 32'd0);
      apply_dispatch(6'd20, 1'b1, 4'b0010, 1'b0, 4'b0000);
      tick();
      set_idle();
      check_output("t5_reuse_occ", 32'(bus_if.occupancy), 32'd8);
      check_output("t5_reuse_free", 32'(bus_if.entry_free), 32'd0);
      bus_if.wakeup_vec = 4'b1010;
      tick();
      bus_if.wakeup_vec = 4'b0000;
      bus_if.issue_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check_output("t5_age_tag", 32'(bus_if.issue_tag), 32'(order5[i]));
         tick();
      end
      bus_if.issue_ready = 1'b0;
      check_output("t5_empty_occ", 32'(bus_if.occupancy), 32'd0);

      // Flush beats a concurrent dispatch
      for (int t = 0; t < 4; t++) begin
         apply_dispatch(6'(30 + t), 1'b1, 4'b1000, 1'b0, 4'b0000);
         tick();
      end
      set_idle();
      check_output("t6_pre_occ", 32'(bus_if.occupancy), 32'd4);
      apply_dispatch(6'd40, 1'b0, 4'b0000, 1'b0, 4'b0000);
      bus_if.flush = 1'b1;
      tick();
      set_idle();
      check_output("t6_flush_occ", 32'(bus_if.occupancy), 32'd0);
      check_output("t6_flush_free", 32'(bus_if.entry_free), 32'd1);
      check_output("t6_flush_valid", 32'(bus_if.issue_valid), 32'd0);
      tick();
      check_output("t6_after_valid", 32'(bus_if.issue_valid), 32'd0);

      // Reset mid-operation
      apply_dispatch(6'd7, 1'b0, 4'b0000, 1'b0, 4'b0000);
      tick();
      set_idle();
      check_output("t7_pre_valid", 32'(bus_if.issue_valid), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_output("t7_rst_valid", 32'(bus_if.issue_valid), 32'd0);
      check_output("t7_rst_tag", 32'(bus_if.issue_tag), 32'd0);
      check_output("t7_rst_occ", 32'(bus_if.occupancy), 32'd0);
      check_output("t7_rst_free", 32'(bus_if.entry_free), 32'd1);

      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end

endmodule
